// File: rtl/pipe_ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_unit_pkg
//  Description : Shared opcode/funct codes, ALU/extender encodings, pipeline
//                control bundle types and FSM state type for pipe_ctrl_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_unit_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] c_OP_RTYPE = 6'h00,
                           c_OP_J     = 6'h02,
                           c_OP_BEQ   = 6'h04,
                           c_OP_BNE   = 6'h05,
                           c_OP_ADDI  = 6'h08,
                           c_OP_ORI   = 6'h0D,
                           c_OP_LUI   = 6'h0F,
                           c_OP_LW    = 6'h23,
                           c_OP_SW    = 6'h2B;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] c_FN_SLL   = 6'h00,
                           c_FN_SRL   = 6'h02,
                           c_FN_SRA   = 6'h03,
                           c_FN_BREAK = 6'h0D,
                           c_FN_ADDU  = 6'h21,
                           c_FN_SUBU  = 6'h23,
                           c_FN_AND   = 6'h24,
                           c_FN_OR    = 6'h25,
                           c_FN_XOR   = 6'h26,
                           c_FN_SLT   = 6'h2A;

    // ALU operation codes; ADDU is zero so a bubble is an all-zero bundle
    localparam int unsigned c_ALUOP_ADDU = 0,
                            c_ALUOP_ADD  = 1,
                            c_ALUOP_SUBU = 2,
                            c_ALUOP_SLT  = 3,
                            c_ALUOP_AND  = 4,
                            c_ALUOP_OR   = 5,
                            c_ALUOP_XOR  = 6,
                            c_ALUOP_SLL  = 7,
                            c_ALUOP_SRL  = 8,
                            c_ALUOP_SRA  = 9;

    // Immediate extender selects
    localparam int unsigned c_EXT_ZERO    = 0,
                            c_EXT_SIGNED  = 1,
                            c_EXT_HIGHPOS = 2;

    // Run / drain-after-BREAK / halted
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pcu_state_e;

    // Single-bit controls decoded in ID and carried into EX
    typedef struct packed {
        logic regw;
        logic mem2r;
        logic memr;
        logic memw;
        logic branch;
        logic nbranch;
        logic alusrc;
        logic alushift;
    } ctrl_flags_t;

    // Controls still needed once the instruction has left EX
    typedef struct packed {
        logic regw;
        logic mem2r;
        logic memr;
        logic memw;
    } mem_flags_t;

    // Controls still needed in write-back
    typedef struct packed {
        logic regw;
        logic mem2r;
    } wb_flags_t;

    localparam ctrl_flags_t c_CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_unit_ctrl_decode
//  Description : Purely combinational ID-stage decoder (ctrl_decode): maps
//                opcode/funct to a control bundle, flags J / BREAK / illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit_ctrl_decode
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int ALUOP_W = 5,
    parameter int EXT_W   = 2,
    parameter int RA_W    = 5
) (
    input  logic               i_valid,
    input  logic [5:0]         i_opcode,
    input  logic [5:0]         i_funct,
    input  logic [RA_W-1:0]    i_rt,
    input  logic [RA_W-1:0]    i_rd,
    output ctrl_flags_t        o_flags,
    output logic [ALUOP_W-1:0] o_aluctrl,
    output logic [EXT_W-1:0]   o_extop,
    output logic [RA_W-1:0]    o_wreg,
    output logic               o_jump,
    output logic               o_brk,
    output logic               o_illegal
);

    logic            w_regdst;
    logic [RA_W-1:0] w_dest;

    // Decode the instruction in ID; anything unrecognised leaves the bubble defaults
    always_comb begin
        o_flags   = c_CTRL_BUBBLE;
        o_aluctrl = ALUOP_W'(c_ALUOP_ADDU);
        o_extop   = EXT_W'(c_EXT_ZERO);
        o_wreg    = '0;
        o_jump    = 1'b0;
        o_brk     = 1'b0;
        o_illegal = 1'b0;
        w_regdst  = 1'b0;
        w_dest    = '0;
        if (i_valid) begin
            case (i_opcode)
                c_OP_RTYPE: begin
                    w_regdst     = 1'b1;
                    o_flags.regw = 1'b1;
                    case (i_funct)
                        c_FN_ADDU: o_aluctrl = ALUOP_W'(c_ALUOP_ADDU);
                        c_FN_SUBU: o_aluctrl = ALUOP_W'(c_ALUOP_SUBU);
                        c_FN_SLT:  o_aluctrl = ALUOP_W'(c_ALUOP_SLT);
                        c_FN_AND:  o_aluctrl = ALUOP_W'(c_ALUOP_AND);
                        c_FN_OR:   o_aluctrl = ALUOP_W'(c_ALUOP_OR);
                        c_FN_XOR:  o_aluctrl = ALUOP_W'(c_ALUOP_XOR);
                        c_FN_SLL: begin
                            o_flags.alushift = 1'b1;
                            o_aluctrl        = ALUOP_W'(c_ALUOP_SLL);
                        end
                        c_FN_SRL: begin
                            o_flags.alushift = 1'b1;
                            o_aluctrl        = ALUOP_W'(c_ALUOP_SRL);
                        end
                        c_FN_SRA: begin
                            o_flags.alushift = 1'b1;
                            o_aluctrl        = ALUOP_W'(c_ALUOP_SRA);
                        end
                        c_FN_BREAK: begin
                            o_flags.regw = 1'b0;
                            o_brk        = 1'b1;
                        end
                        default: begin
                            o_flags.regw = 1'b0;
                            o_illegal    = 1'b1;
                        end
                    endcase
                end
                c_OP_ORI: begin
                    o_flags.regw   = 1'b1;
                    o_flags.alusrc = 1'b1;
                    o_aluctrl      = ALUOP_W'(c_ALUOP_OR);
                    o_extop        = EXT_W'(c_EXT_ZERO);
                end
                c_OP_LUI: begin
                    // rs is $0 for LUI, so rs + (imm << 16) yields the result
                    o_flags.regw   = 1'b1;
                    o_flags.alusrc = 1'b1;
                    o_aluctrl      = ALUOP_W'(c_ALUOP_ADDU);
                    o_extop        = EXT_W'(c_EXT_HIGHPOS);
                end
                c_OP_ADDI: begin
                    o_flags.regw   = 1'b1;
                    o_flags.alusrc = 1'b1;
                    o_aluctrl      = ALUOP_W'(c_ALUOP_ADD);
                    o_extop        = EXT_W'(c_EXT_SIGNED);
                end
                c_OP_LW: begin
                    o_flags.regw   = 1'b1;
                    o_flags.mem2r  = 1'b1;
                    o_flags.memr   = 1'b1;
                    o_flags.alusrc = 1'b1;
                    o_extop        = EXT_W'(c_EXT_SIGNED);
                end
                c_OP_SW: begin
                    o_flags.memw   = 1'b1;
                    o_flags.alusrc = 1'b1;
                    o_extop        = EXT_W'(c_EXT_SIGNED);
                end
                c_OP_BEQ: begin
                    o_flags.branch = 1'b1;
                    o_aluctrl      = ALUOP_W'(c_ALUOP_SUBU);
                    o_extop        = EXT_W'(c_EXT_SIGNED);
                end
                c_OP_BNE: begin
                    o_flags.nbranch = 1'b1;
                    o_aluctrl       = ALUOP_W'(c_ALUOP_SUBU);
                    o_extop         = EXT_W'(c_EXT_SIGNED);
                end
                c_OP_J: begin
                    // Resolved in ID; the J itself travels on as a bubble
                    o_jump = 1'b1;
                end
                default: begin
                    o_illegal = 1'b1;
                end
            endcase
            // Writes to $0 are dropped; wreg is only meaningful when regw is set
            w_dest = w_regdst ? i_rd : i_rt;
            if (o_flags.regw && (w_dest != '0)) begin
                o_wreg = w_dest;
            end else begin
                o_flags.regw = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_unit
//  Description : Pipelined MIPS control unit. Carries decoded controls through
//                ID/EX, EX/MEM, MEM/WB; handles load-use stalls, branch/jump
//                squash and the BREAK drain-then-halt sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int ALUOP_W  = 5,
    parameter int EXT_W    = 2,
    parameter int RA_W     = 5,
    parameter int DRAIN    = 3,
    parameter int ILLCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [5:0]          id_opcode,
    input  logic [5:0]          id_funct,
    input  logic [RA_W-1:0]     id_rs,
    input  logic [RA_W-1:0]     id_rt,
    input  logic [RA_W-1:0]     id_rd,
    input  logic                ex_zero,
    output logic                ifid_en,
    output logic                ifid_flush,
    output logic                pc_jump,
    output logic                pc_branch,
    output logic                ex_alusrc,
    output logic                ex_alushift,
    output logic [ALUOP_W-1:0]  ex_aluctrl,
    output logic [EXT_W-1:0]    ex_extop,
    output logic [RA_W-1:0]     ex_wreg,
    output logic                mem_memr,
    output logic                mem_memw,
    output logic                wb_regw,
    output logic                wb_mem2r,
    output logic [RA_W-1:0]     wb_wreg,
    output logic                halted,
    output logic                illegal,
    output logic [ILLCNT_W-1:0] illegal_cnt
);

    // Counter sized so that DRAIN-1 always fits, including DRAIN == 1
    localparam int                 c_CNT_W      = $clog2(DRAIN + 1);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LOAD = c_CNT_W'(DRAIN - 1);

    // ID-stage decode results
    ctrl_flags_t        w_dec_flags;
    logic [ALUOP_W-1:0] w_dec_aluctrl;
    logic [EXT_W-1:0]   w_dec_extop;
    logic [RA_W-1:0]    w_dec_wreg;
    logic               w_dec_jump;
    logic               w_dec_brk;
    logic               w_dec_illegal;

    // Stage registers
    ctrl_flags_t        r_ex_flags;
    logic [ALUOP_W-1:0] r_ex_aluctrl;
    logic [EXT_W-1:0]   r_ex_extop;
    logic [RA_W-1:0]    r_ex_wreg;
    mem_flags_t         r_mem_flags;
    logic [RA_W-1:0]    r_mem_wreg;
    wb_flags_t          r_wb_flags;
    logic [RA_W-1:0]    r_wb_wreg;

    // Control FSM and bookkeeping
    pcu_state_e          r_state;
    pcu_state_e          w_state_nxt;
    logic [c_CNT_W-1:0]  r_drain_cnt;
    logic [c_CNT_W-1:0]  w_drain_cnt_nxt;
    logic [ILLCNT_W-1:0] r_ill_cnt;

    // Hazard / redirect terms
    logic w_run;
    logic w_pc_branch;
    logic w_loaduse;
    logic w_stall;
    logic w_jump_go;
    logic w_brk_go;
    logic w_ex_bubble;

    pipe_ctrl_unit_ctrl_decode #(
        .ALUOP_W (ALUOP_W),
        .EXT_W   (EXT_W),
        .RA_W    (RA_W)
    ) u_ctrl_decode (
        .i_valid   (id_valid),
        .i_opcode  (id_opcode),
        .i_funct   (id_funct),
        .i_rt      (id_rt),
        .i_rd      (id_rd),
        .o_flags   (w_dec_flags),
        .o_aluctrl (w_dec_aluctrl),
        .o_extop   (w_dec_extop),
        .o_wreg    (w_dec_wreg),
        .o_jump    (w_dec_jump),
        .o_brk     (w_dec_brk),
        .o_illegal (w_dec_illegal)
    );

    // Resolve redirects and stalls; taken branch beats load-use, which beats jump
    always_comb begin
        w_run       = (r_state == ST_RUN);
        w_pc_branch = (r_ex_flags.branch & ex_zero) | (r_ex_flags.nbranch & ~ex_zero);
        w_loaduse   = r_ex_flags.memr && (r_ex_wreg != '0) &&
                      ((r_ex_wreg == id_rs) || (r_ex_wreg == id_rt));
        w_stall     = w_loaduse & ~w_pc_branch;
        w_jump_go   = w_run & w_dec_jump & ~w_pc_branch & ~w_loaduse;
        w_brk_go    = w_run & w_dec_brk & ~w_pc_branch & ~w_loaduse;
        w_ex_bubble = ~w_run | w_pc_branch | w_loaduse;
    end

    assign pc_branch   = w_pc_branch;
    assign pc_jump     = w_jump_go;
    assign ifid_flush  = w_pc_branch | w_jump_go;
    // Hold the front end on a stall, while accepting BREAK, and once draining/halted
    assign ifid_en     = w_run & ~w_stall & ~w_brk_go;
    // A held (stalled) or squashed instruction must not be reported twice
    assign illegal     = w_dec_illegal & w_run & ~w_pc_branch & ~w_stall;
    assign illegal_cnt = r_ill_cnt;
    assign halted      = (r_state == ST_HALTED);

    assign ex_alusrc   = r_ex_flags.alusrc;
    assign ex_alushift = r_ex_flags.alushift;
    assign ex_aluctrl  = r_ex_aluctrl;
    assign ex_extop    = r_ex_extop;
    assign ex_wreg     = r_ex_wreg;
    assign mem_memr    = r_mem_flags.memr;
    assign mem_memw    = r_mem_flags.memw;
    assign wb_regw     = r_wb_flags.regw;
    assign wb_mem2r    = r_wb_flags.mem2r;
    assign wb_wreg     = r_wb_wreg;

    // Next state of the BREAK drain sequencer
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_brk_go) begin
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = c_DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - c_CNT_W'(1);
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt     = ST_RUN;
                w_drain_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state and drain counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    // Advance control bundles ID->EX->MEM->WB, injecting bubbles into EX when needed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_flags   <= c_CTRL_BUBBLE;
            r_ex_aluctrl <= ALUOP_W'(c_ALUOP_ADDU);
            r_ex_extop   <= EXT_W'(c_EXT_ZERO);
            r_ex_wreg    <= '0;
            r_mem_flags  <= '0;
            r_mem_wreg   <= '0;
            r_wb_flags   <= '0;
            r_wb_wreg    <= '0;
        end else begin
            if (w_ex_bubble) begin
                r_ex_flags   <= c_CTRL_BUBBLE;
                r_ex_aluctrl <= ALUOP_W'(c_ALUOP_ADDU);
                r_ex_extop   <= EXT_W'(c_EXT_ZERO);
                r_ex_wreg    <= '0;
            end else begin
                r_ex_flags   <= w_dec_flags;
                r_ex_aluctrl <= w_dec_aluctrl;
                r_ex_extop   <= w_dec_extop;
                r_ex_wreg    <= w_dec_wreg;
            end
            r_mem_flags.regw  <= r_ex_flags.regw;
            r_mem_flags.mem2r <= r_ex_flags.mem2r;
            r_mem_flags.memr  <= r_ex_flags.memr;
            r_mem_flags.memw  <= r_ex_flags.memw;
            r_mem_wreg        <= r_ex_wreg;
            r_wb_flags.regw   <= r_mem_flags.regw;
            r_wb_flags.mem2r  <= r_mem_flags.mem2r;
            r_wb_wreg         <= r_mem_wreg;
        end
    end

    // Saturating count of reported illegal instructions
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ill_cnt <= '0;
        end else if (illegal && (r_ill_cnt != '1)) begin
            r_ill_cnt <= r_ill_cnt + ILLCNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl_unit
//  Description : Directed self-checking bench for pipe_ctrl_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

    // Expected encodings, written out by hand
    localparam logic [4:0] c_ADDU = 5'd0, c_ADD = 5'd1, c_SUBU = 5'd2, c_SLT = 5'd3,
                           c_AND  = 5'd4, c_OR  = 5'd5, c_XOR  = 5'd6, c_SLL = 5'd7,
                           c_SRL  = 5'd8, c_SRA = 5'd9;
    localparam logic [1:0] c_EZ = 2'd0, c_ES = 2'd1, c_EH = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [5:0] id_opcode = '0;
    logic [5:0] id_funct = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       ex_zero = 1'b0;
    logic       ifid_en, ifid_flush, pc_jump, pc_branch;
    logic       ex_alusrc, ex_alushift;
    logic [4:0] ex_aluctrl;
    logic [1:0] ex_extop;
    logic [4:0] ex_wreg;
    logic       mem_memr, mem_memw, wb_regw, wb_mem2r;
    logic [4:0] wb_wreg;
    logic       halted, illegal;
    logic [7:0] illegal_cnt;

    int checks = 0;
    int errors = 0;

    logic [26:0] dec_vec [0:12];
    logic [13:0] dec_exp [0:12];

    pipe_ctrl_unit #(
        .ALUOP_W(5), .EXT_W(2), .RA_W(5), .DRAIN(3), .ILLCNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_zero(ex_zero), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .pc_jump(pc_jump), .pc_branch(pc_branch), .ex_alusrc(ex_alusrc),
        .ex_alushift(ex_alushift), .ex_aluctrl(ex_aluctrl), .ex_extop(ex_extop),
        .ex_wreg(ex_wreg), .mem_memr(mem_memr), .mem_memw(mem_memw),
        .wb_regw(wb_regw), .wb_mem2r(wb_mem2r), .wb_wreg(wb_wreg),
        .halted(halted), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_funct  = fn;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        #1;
    endtask

    task automatic idle;
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic do_reset;
        rst     = 1'b1;
        ex_zero = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({ifid_en, ifid_flush, pc_jump, pc_branch, halted, illegal} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 100000",
                     {ifid_en, ifid_flush, pc_jump, pc_branch, halted, illegal});
        end
        checks++;
        if (illegal_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_illcnt got %0d want 0", illegal_cnt);
        end
        // Fill the pipe with a load, then reset while it sits in MEM
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
        tick();
        idle();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ex_alusrc, ex_alushift, ex_aluctrl, ex_extop, ex_wreg, mem_memr, mem_memw,
             wb_regw, wb_mem2r, wb_wreg} !== 23'd0) begin
            errors++;
            $display("FAIL reset_stages got %h want 0",
                     {ex_alusrc, ex_alushift, ex_aluctrl, ex_extop, ex_wreg, mem_memr,
                      mem_memw, wb_regw, wb_mem2r, wb_wreg});
        end
    endtask

    task automatic test_addu;
        do_reset();
        drive(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3);
        tick();
        idle();
        checks++;
        if ({ex_aluctrl, ex_wreg, ex_alusrc} !== {c_ADDU, 5'd3, 1'b0}) begin
            errors++;
            $display("FAIL addu_ex got %h want %h", {ex_aluctrl, ex_wreg, ex_alusrc},
                     {c_ADDU, 5'd3, 1'b0});
        end
        tick();
        checks++;
        if (wb_regw !== 1'b0) begin
            errors++;
            $display("FAIL addu_wb_early got %b want 0", wb_regw);
        end
        tick();
        checks++;
        if ({wb_regw, wb_mem2r, wb_wreg} !== {1'b1, 1'b0, 5'd3}) begin
            errors++;
            $display("FAIL addu_wb got %h want %h", {wb_regw, wb_mem2r, wb_wreg},
                     {1'b1, 1'b0, 5'd3});
        end
    endtask

    task automatic test_decode;
        // {op, funct, rs, rt, rd} -> {alusrc, alushift, aluctrl, extop, wreg}
        dec_vec[0]  = {6'h00, 6'h23, 5'd1, 5'd2,  5'd4};  dec_exp[0]  = {2'b00, c_SUBU, c_EZ, 5'd4};
        dec_vec[1]  = {6'h00, 6'h2A, 5'd1, 5'd2,  5'd5};  dec_exp[1]  = {2'b00, c_SLT,  c_EZ, 5'd5};
        dec_vec[2]  = {6'h00, 6'h00, 5'd0, 5'd2,  5'd6};  dec_exp[2]  = {2'b01, c_SLL,  c_EZ, 5'd6};
        dec_vec[3]  = {6'h00, 6'h03, 5'd0, 5'd2,  5'd7};  dec_exp[3]  = {2'b01, c_SRA,  c_EZ, 5'd7};
        dec_vec[4]  = {6'h00, 6'h26, 5'd1, 5'd2,  5'd8};  dec_exp[4]  = {2'b00, c_XOR,  c_EZ, 5'd8};
        dec_vec[5]  = {6'h0D, 6'h11, 5'd1, 5'd9,  5'd31}; dec_exp[5]  = {2'b10, c_OR,   c_EZ, 5'd9};
        dec_vec[6]  = {6'h0F, 6'h11, 5'd0, 5'd10, 5'd31}; dec_exp[6]  = {2'b10, c_ADDU, c_EH, 5'd10};
        dec_vec[7]  = {6'h08, 6'h11, 5'd1, 5'd11, 5'd31}; dec_exp[7]  = {2'b10, c_ADD,  c_ES, 5'd11};
        dec_vec[8]  = {6'h2B, 6'h11, 5'd1, 5'd12, 5'd31}; dec_exp[8]  = {2'b10, c_ADDU, c_ES, 5'd0};
        dec_vec[9]  = {6'h00, 6'h21, 5'd1, 5'd2,  5'd0};  dec_exp[9]  = {2'b00, c_ADDU, c_EZ, 5'd0};
        dec_vec[10] = {6'h00, 6'h24, 5'd1, 5'd2,  5'd13}; dec_exp[10] = {2'b00, c_AND,  c_EZ, 5'd13};
        dec_vec[11] = {6'h00, 6'h25, 5'd1, 5'd2,  5'd14}; dec_exp[11] = {2'b00, c_OR,   c_EZ, 5'd14};
        dec_vec[12] = {6'h00, 6'h02, 5'd0, 5'd2,  5'd15}; dec_exp[12] = {2'b01, c_SRL,  c_EZ, 5'd15};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, dec_vec[i][26:21], dec_vec[i][20:15], dec_vec[i][14:10],
                  dec_vec[i][9:5], dec_vec[i][4:0]);
            tick();
            checks++;
            if ({ex_alusrc, ex_alushift, ex_aluctrl, ex_extop, ex_wreg} !== dec_exp[i]) begin
                errors++;
                $display("FAIL decode_%0d got %h want %h", i,
                         {ex_alusrc, ex_alushift, ex_aluctrl, ex_extop, ex_wreg}, dec_exp[i]);
            end
        end
        idle();
    endtask

    task automatic test_load_use;
        do_reset();
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);   // LW $5,0($1)
        tick();
        drive(1'b1, 6'h00, 6'h21, 5'd5, 5'd2, 5'd6);   // ADDU $6,$5,$2
        checks++;
        if ({ifid_en, ifid_flush, ex_wreg, mem_memr} !== {1'b0, 1'b0, 5'd5, 1'b0}) begin
            errors++;
            $display("FAIL lu_stall got %h want %h", {ifid_en, ifid_flush, ex_wreg, mem_memr},
                     {1'b0, 1'b0, 5'd5, 1'b0});
        end
        tick();
        checks++;
        if ({ifid_en, mem_memr, ex_aluctrl, ex_wreg, ex_alusrc} !== {1'b1, 1'b1, 11'd0}) begin
            errors++;
            $display("FAIL lu_bubble_ex got %h want %h",
                     {ifid_en, mem_memr, ex_aluctrl, ex_wreg, ex_alusrc}, {1'b1, 1'b1, 11'd0});
        end
        tick();
        idle();
        checks++;
        if ({ex_wreg, mem_memr, mem_memw, wb_regw, wb_mem2r, wb_wreg} !==
            {5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5}) begin
            errors++;
            $display("FAIL lu_wb_load got %h want %h",
                     {ex_wreg, mem_memr, mem_memw, wb_regw, wb_mem2r, wb_wreg},
                     {5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5});
        end
        tick();
        checks++;
        if ({wb_regw, wb_mem2r, wb_wreg} !== 7'd0) begin
            errors++;
            $display("FAIL lu_wb_bubble got %h want 0", {wb_regw, wb_mem2r, wb_wreg});
        end
        tick();
        checks++;
        if ({wb_regw, wb_wreg} !== {1'b1, 5'd6}) begin
            errors++;
            $display("FAIL lu_wb_addu got %h want %h", {wb_regw, wb_wreg}, {1'b1, 5'd6});
        end
    endtask

    task automatic test_branch;
        do_reset();
        drive(1'b1, 6'h04, 6'h00, 5'd1, 5'd2, 5'd0);   // BEQ $1,$2
        tick();
        ex_zero = 1'b0;
        drive(1'b1, 6'h2B, 6'h00, 5'd1, 5'd3, 5'd0);   // SW $3,0($1)
        checks++;
        if ({pc_branch, ex_aluctrl, ex_extop} !== {1'b0, c_SUBU, c_ES}) begin
            errors++;
            $display("FAIL beq_not_taken got %h want %h", {pc_branch, ex_aluctrl, ex_extop},
                     {1'b0, c_SUBU, c_ES});
        end
        ex_zero = 1'b1;
        #1;
        checks++;
        if ({pc_branch, ifid_flush, pc_jump, ifid_en} !== 4'b1101) begin
            errors++;
            $display("FAIL beq_taken got %b want 1101", {pc_branch, ifid_flush, pc_jump, ifid_en});
        end
        tick();
        checks++;
        if ({pc_branch, ex_alusrc, ex_extop} !== 4'b0000) begin
            errors++;
            $display("FAIL beq_squash_ex got %b want 0000", {pc_branch, ex_alusrc, ex_extop});
        end
        idle();
        ex_zero = 1'b0;
        tick();
        checks++;
        if (mem_memw !== 1'b0) begin
            errors++;
            $display("FAIL beq_squash_mem got %b want 0", mem_memw);
        end
    endtask

    task automatic test_jump;
        do_reset();
        drive(1'b1, 6'h05, 6'h00, 5'd1, 5'd2, 5'd0);   // BNE $1,$2
        tick();
        ex_zero = 1'b1;
        drive(1'b1, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0);   // J
        checks++;
        if ({pc_branch, pc_jump} !== 2'b01) begin
            errors++;
            $display("FAIL bne_not_taken got %b want 01", {pc_branch, pc_jump});
        end
        ex_zero = 1'b0;
        #1;
        checks++;
        if ({pc_branch, pc_jump, ifid_flush} !== 3'b101) begin
            errors++;
            $display("FAIL jump_behind_branch got %b want 101", {pc_branch, pc_jump, ifid_flush});
        end
        tick();
        checks++;
        if ({pc_branch, pc_jump, ifid_flush, ifid_en, ex_wreg} !== {4'b0111, 5'd0}) begin
            errors++;
            $display("FAIL jump_alone got %h want %h",
                     {pc_branch, pc_jump, ifid_flush, ifid_en, ex_wreg}, {4'b0111, 5'd0});
        end
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);   // LW $5
        tick();
        drive(1'b1, 6'h02, 6'h00, 5'd5, 5'd0, 5'd0);   // J whose rs field hits $5
        checks++;
        if ({pc_jump, ifid_en, ifid_flush} !== 3'b000) begin
            errors++;
            $display("FAIL jump_under_stall got %b want 000", {pc_jump, ifid_en, ifid_flush});
        end
        tick();
        checks++;
        if ({pc_jump, ifid_flush} !== 2'b11) begin
            errors++;
            $display("FAIL jump_after_stall got %b want 11", {pc_jump, ifid_flush});
        end
        idle();
    endtask

    task automatic test_illegal;
        int exp_cnt;
        do_reset();
        drive(1'b1, 6'h00, 6'h01, 5'd1, 5'd2, 5'd3);   // undefined funct
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL ill_funct got %b want 1", illegal);
        end
        tick();
        checks++;
        if ({illegal_cnt, ex_wreg} !== {8'd1, 5'd0}) begin
            errors++;
            $display("FAIL ill_funct_cnt got %h want %h", {illegal_cnt, ex_wreg}, {8'd1, 5'd0});
        end
        exp_cnt = 1;
        drive(1'b1, 6'h3F, 6'h00, 5'd1, 5'd7, 5'd7);
        for (int k = 0; k < 300; k++) begin
            checks++;
            if (illegal !== 1'b1) begin
                errors++;
                $display("FAIL ill_pulse_%0d got %b want 1", k, illegal);
            end
            tick();
            if (exp_cnt < 255) exp_cnt++;
            checks++;
            if (illegal_cnt !== exp_cnt[7:0]) begin
                errors++;
                $display("FAIL ill_cnt_%0d got %0d want %0d", k, illegal_cnt, exp_cnt);
            end
            checks++;
            if ({mem_memw, wb_regw, ex_wreg, ex_alusrc} !== 8'd0) begin
                errors++;
                $display("FAIL ill_side_%0d got %h want 0", k, {mem_memw, wb_regw, ex_wreg, ex_alusrc});
            end
        end
        drive(1'b0, 6'h3F, 6'h00, 5'd1, 5'd7, 5'd7);
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL ill_invalid got %b want 0", illegal);
        end
        tick();
        checks++;
        if (illegal_cnt !== 8'd255) begin
            errors++;
            $display("FAIL ill_sat_hold got %0d want 255", illegal_cnt);
        end
        idle();
    endtask

    task automatic test_break;
        do_reset();
        drive(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3);   // ADDU $3 ahead of BREAK
        tick();
        drive(1'b1, 6'h00, 6'h0D, 5'd0, 5'd0, 5'd0);   // BREAK
        checks++;
        if ({ifid_en, halted} !== 2'b00) begin
            errors++;
            $display("FAIL brk_accept got %b want 00", {ifid_en, halted});
        end
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++;
            if ({halted, ifid_en} !== {(e >= 4), 1'b0}) begin
                errors++;
                $display("FAIL brk_halt_e%0d got %b want %b", e, {halted, ifid_en}, {(e >= 4), 1'b0});
            end
            if (e == 2) begin
                checks++;
                if ({wb_regw, wb_wreg} !== {1'b1, 5'd3}) begin
                    errors++;
                    $display("FAIL brk_drain_wb got %h want %h", {wb_regw, wb_wreg}, {1'b1, 5'd3});
                end
            end
        end
        drive(1'b1, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0);
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL halted_illegal got %b want 0", illegal);
        end
        drive(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd4);
        tick();
        tick();
        tick();
        checks++;
        if ({halted, ex_wreg, wb_regw, ifid_en} !== {1'b1, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL halted_bubbles got %h want %h", {halted, ex_wreg, wb_regw, ifid_en},
                     {1'b1, 5'd0, 1'b0, 1'b0});
        end
        // Reset in the middle of a drain
        do_reset();
        drive(1'b1, 6'h00, 6'h0D, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        for (int e = 0; e < 4; e++) begin
            tick();
            checks++;
            if ({halted, ifid_en} !== 2'b01) begin
                errors++;
                $display("FAIL brk_rst_e%0d got %b want 01", e, {halted, ifid_en});
            end
        end
    endtask

    task automatic test_break_stall;
        do_reset();
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);   // LW $5
        tick();
        drive(1'b1, 6'h00, 6'h0D, 5'd5, 5'd0, 5'd0);   // BREAK with rs field = $5
        checks++;
        if (ifid_en !== 1'b0) begin
            errors++;
            $display("FAIL brk_stall_hold got %b want 0", ifid_en);
        end
        tick();
        for (int e = 3; e <= 6; e++) begin
            tick();
            checks++;
            if (halted !== (e >= 6)) begin
                errors++;
                $display("FAIL brk_stall_e%0d got %b want %b", e, halted, (e >= 6));
            end
        end
        idle();
    endtask

    task automatic test_back_to_back;
        logic [4:0] exp_ex;
        logic [5:0] exp_wb;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'(c + 1));
            else       idle();
            tick();
            exp_ex = (c < 4) ? 5'(c + 1) : 5'd0;
            exp_wb = (c >= 2 && c < 6) ? {1'b1, 5'(c - 1)} : 6'd0;
            checks++;
            if ({ex_wreg, wb_regw, wb_wreg} !== {exp_ex, exp_wb}) begin
                errors++;
                $display("FAIL b2b_c%0d got %h want %h", c, {ex_wreg, wb_regw, wb_wreg},
                         {exp_ex, exp_wb});
            end
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_decode();
        test_load_use();
        test_branch();
        test_jump();
        test_illegal();
        test_break();
        test_break_stall();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
